layer6_argmax: RTL and testbench
================================

// Module: layer6_argmax
// PURPOSE
//  Consumes the ReLU outputs of the final node layer and reports the index of the largest activation as the class decision.
//  Captures all node outputs in one valid/ready transfer, then scans them serially, one per cycle, to keep the comparator count at one.
//  Drives a result with valid/ready towards the host/UART reporting logic.
// PARAMETERS
//  NUM_NODES  16  number of node outputs to compare (>=2)
//  DW         16  width of each node output, treated as unsigned (post-ReLU, bit DW-1 is always 0 from upstream)
//  IW         $clog2(NUM_NODES)  width of the class index (localparam, not overridable)
// PORTS
//  clk        in   1             clock
//  reset      in   1             synchronous, active-high reset
//  in_valid   in   1             node_vec holds a complete, settled layer result
//  in_ready   out  1             block can accept node_vec
//  node_vec   in   NUM_NODES*DW  node i occupies bits [i*DW +: DW]
//  out_valid  out  1             class_idx valid
//  out_ready  in   1             consumer accepts result
//  class_idx  out  IW            index of the maximum node
//  max_score  out  DW            maximum value; present only with ARGMAX_SCORE_EN
// BEHAVIOUR
//  Reset: reset is synchronous, active-high; clock is clk. All of the following happen on the reset edge:
//   - in_ready=0 during reset and 1 in the cycle after.
//   - out_valid=0, class_idx=0, max_score=0.
//   - State returns to IDLE. The capture register, the scan counter and the running best are cleared.
//  FSM: IDLE -> SCAN -> DONE -> IDLE.
//   - IDLE: in_ready=1. When in_valid=1, node_vec is copied into the capture register and the FSM goes to SCAN.
//     The running best is set to node 0, the best index to 0, and the scan counter to 1.
//   - SCAN: in_ready=0. Each cycle, capture[cnt] is compared with the running best using strict greater-than, so ties keep the lower index.
//     cnt increments each cycle. After the compare at cnt==NUM_NODES-1, the FSM goes to DONE.
//   - DONE: out_valid=1. class_idx and max_score are held stable. When out_ready=1, the FSM goes to IDLE and out_valid drops on the next edge.
//  Latency: accept edge plus NUM_NODES-1 scan cycles. out_valid rises NUM_NODES cycles after the accepting edge.
//  Throughput: one decision per NUM_NODES+1 cycles when out_ready is held at 1.
//  in_ready is a registered state decode and does not depend combinationally on in_valid or out_ready.
//  in_valid outside IDLE is ignored, and node_vec changes during SCAN have no effect (the scan reads the capture register only).
//  out_ready outside DONE is ignored.
//  All-zero input gives class_idx=0 and max_score=0.
//  Comparison is unsigned, full DW bits, with no saturation or rounding.
//  Reset mid-SCAN or in DONE abandons the result, and out_valid is 0 from the next edge.
// CONFIGURATION
//  ARGMAX_SCORE_EN defined:
//   - The max_score port exists.
//   - It carries the winning value with the same timing as class_idx, and is 0 at reset.
//  ARGMAX_SCORE_EN undefined:
//   - The max_score port is absent.
//   - The running-best register is still required internally.
//   - Decision behaviour is unchanged.
// STRUCTURE
//  Shared package: the DW default, the state enum typedef (IDLE/SCAN/DONE), and the node-word typedef logic [DW-1:0].
//  Everything lives in a single module with no sub-module. The FSM, scan counter and comparator are small enough to stay inline.
// TESTING
//  1. Reset: assert reset for 2 cycles -> in_ready=1 and out_valid=0 afterwards; class_idx=0.
//  2. Single max: node 5=0x0123, all others 0x0010 -> out_valid exactly 16 cycles after accept; class_idx=5; max_score=0x0123.
//  3. Tie: node 3 and node 12 both 0x7FFF, others 0 -> class_idx=3.
//  4. Max at the end: node 15=0x0001, others 0 -> class_idx=15. All zero -> class_idx=0.
//  5. Back-pressure: hold out_ready=0 for 20 cycles in DONE -> class_idx stable, in_ready=0, in_valid ignored.
//     Then raise out_ready -> in_ready=1 one cycle later.
//  6. Reset mid-scan: assert reset at scan cycle 7 -> out_valid never rises for that input. The next input is processed correctly.

Source files
------------

// File: rtl/layer6_argmax_pkg.sv
// Shared definitions for the final-layer argmax block: default node width,
// FSM state encoding and the node-word type.
package layer6_argmax_pkg;

    localparam int ARGMAX_DW = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef logic [ARGMAX_DW-1:0] node_t;

endpackage

// File: rtl/layer6_argmax.sv
// Final-layer argmax: captures all node activations in one valid/ready
// transfer, scans them serially with a single unsigned comparator and
// reports the index of the largest value. Ties keep the lower index.
// Optional feature macro: ARGMAX_SCORE_EN exports the winning value on
// max_score; without it the running best stays internal.
module layer6_argmax
    import layer6_argmax_pkg::*;
#(
    parameter  int NUM_NODES = 16,
    parameter  int DW        = ARGMAX_DW,
    localparam int IW        = $clog2(NUM_NODES)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_NODES*DW-1:0] node_vec,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [IW-1:0]           class_idx
`ifdef ARGMAX_SCORE_EN
    ,
    output logic [DW-1:0]           max_score
`endif
);

    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_NODES - 1);

    state_t          state_q, state_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [IW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   best_idx_q, best_idx_d;
    logic [DW-1:0]   best_q, best_d;
    logic [IW-1:0]   class_q, class_d;
    logic [DW-1:0]   cap_q [NUM_NODES];
    logic [DW-1:0]   cap_d [NUM_NODES];
`ifdef ARGMAX_SCORE_EN
    logic [DW-1:0]   score_q, score_d;
`endif

    logic            accept_s;
    logic            cand_gt_s;
    logic [IW-1:0]   win_idx_s;
    logic [DW-1:0]   win_val_s;

    // in_ready is registered, so a handshake only fires once the FSM is
    // really sitting in IDLE.
    assign accept_s  = in_ready_q & in_valid;
    assign cand_gt_s = cap_q[cnt_q] > best_q;
    assign win_idx_s = cand_gt_s ? cnt_q : best_idx_q;
    assign win_val_s = cand_gt_s ? cap_q[cnt_q] : best_q;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        best_d     = best_q;
        best_idx_d = best_idx_q;
        class_d    = class_q;
        cap_d      = cap_q;
`ifdef ARGMAX_SCORE_EN
        score_d    = score_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    for (int i = 0; i < NUM_NODES; i++) begin
                        cap_d[i] = node_vec[i*DW +: DW];
                    end
                    best_d     = node_vec[DW-1:0];
                    best_idx_d = '0;
                    cnt_d      = IW'(1);
                    state_d    = ST_SCAN;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_SCAN: begin
                best_d     = win_val_s;
                best_idx_d = win_idx_s;
                cnt_d      = cnt_q + IW'(1);
                if (cnt_q == LAST_IDX) begin
                    class_d = win_idx_s;
`ifdef ARGMAX_SCORE_EN
                    score_d = win_val_s;
`endif
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SCAN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture register, scan counter, running best and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
            best_q      <= '0;
            best_idx_q  <= '0;
            class_q     <= '0;
            for (int i = 0; i < NUM_NODES; i++) begin
                cap_q[i] <= '0;
            end
`ifdef ARGMAX_SCORE_EN
            score_q     <= '0;
`endif
        end else begin
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
            best_q      <= best_d;
            best_idx_q  <= best_idx_d;
            class_q     <= class_d;
            cap_q       <= cap_d;
`ifdef ARGMAX_SCORE_EN
            score_q     <= score_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign class_idx = class_q;
`ifdef ARGMAX_SCORE_EN
    assign max_score = score_q;
`else
    // Score not exported; best_q remains purely internal scan state.
`endif

endmodule

// File: tb/tb_layer6_argmax.sv
// Directed self-checking bench for layer6_argmax (NUM_NODES=16, DW=16).
module tb_layer6_argmax;

    localparam int NN = 16;
    localparam int DW = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [NN*DW-1:0]   node_vec;
    logic               out_valid;
    logic               out_ready;
    logic [3:0]         class_idx;
`ifdef ARGMAX_SCORE_EN
    logic [DW-1:0]      max_score;
`endif

    int vectors = 0;
    int errors  = 0;

    layer6_argmax #(.NUM_NODES(NN), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .node_vec  (node_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .class_idx (class_idx)
`ifdef ARGMAX_SCORE_EN
        ,
        .max_score (max_score)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fill(output logic [NN*DW-1:0] v, input logic [15:0] val);
        for (int i = 0; i < NN; i++) v[i*DW +: DW] = val;
    endtask

    // Wait for in_ready, transfer vec, scramble node_vec during the scan,
    // then check exact latency and the decision. The accept edge counts as
    // edge 1, so out_valid must be low after 15 edges and high after 16.
    task automatic run_vec(input string name, input logic [NN*DW-1:0] vec,
                           input logic [3:0] exp_idx, input logic [15:0] exp_score,
                           input bit release_out);
        logic [NN*DW-1:0] scr;
        bit early;
        int w;
        w = 0;
        while (in_ready !== 1'b1 && w < 5) begin
            tick();
            w++;
        end
        chk({name, " in_ready before accept"}, {31'd0, in_ready}, 32'd1);
        node_vec = vec;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        fill(scr, 16'h0000);
        scr[1*DW +: DW] = 16'h7FFF;
        node_vec = scr;
        chk({name, " in_ready after accept"}, {31'd0, in_ready}, 32'd0);
        early = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (out_valid !== 1'b0) early = 1'b1;
        end
        chk({name, " out_valid early"}, {31'd0, early}, 32'd0);
        tick();
        chk({name, " out_valid latency"}, {31'd0, out_valid}, 32'd1);
        chk({name, " class_idx"}, {28'd0, class_idx}, {28'd0, exp_idx});
`ifdef ARGMAX_SCORE_EN
        chk({name, " max_score"}, {16'd0, max_score}, {16'd0, exp_score});
`else
        if (exp_score === 16'hxxxx) $display("unexpected x score for %s", name);
`endif
        if (release_out) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk({name, " out_valid drop"}, {31'd0, out_valid}, 32'd0);
            chk({name, " in_ready return"}, {31'd0, in_ready}, 32'd1);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        chk("reset in_ready during", {31'd0, in_ready}, 32'd0);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset class_idx", {28'd0, class_idx}, 32'd0);
`ifdef ARGMAX_SCORE_EN
        chk("reset max_score", {16'd0, max_score}, 32'd0);
`endif
        reset = 1'b0;
        tick();
        chk("reset in_ready after", {31'd0, in_ready}, 32'd1);
        chk("reset out_valid after", {31'd0, out_valid}, 32'd0);
    endtask

    task automatic test_single_max();
        logic [NN*DW-1:0] v;
        fill(v, 16'h0010);
        v[5*DW +: DW] = 16'h0123;
        run_vec("single_max", v, 4'd5, 16'h0123, 1'b1);
        fill(v, 16'h7FFE);
        v[0] = 1'b1;
        v[0*DW +: DW] = 16'h7FFF;
        run_vec("max_at_0", v, 4'd0, 16'h7FFF, 1'b1);
        for (int i = 0; i < NN; i++) v[i*DW +: DW] = 16'(i * 3);
        run_vec("ramp", v, 4'd15, 16'd45, 1'b1);
    endtask

    task automatic test_tie();
        logic [NN*DW-1:0] v;
        fill(v, 16'h0000);
        v[3*DW +: DW]  = 16'h7FFF;
        v[12*DW +: DW] = 16'h7FFF;
        run_vec("tie", v, 4'd3, 16'h7FFF, 1'b1);
    endtask

    task automatic test_edges();
        logic [NN*DW-1:0] v;
        fill(v, 16'h0000);
        v[15*DW +: DW] = 16'h0001;
        run_vec("max_at_end", v, 4'd15, 16'h0001, 1'b1);
        fill(v, 16'h0000);
        run_vec("all_zero", v, 4'd0, 16'h0000, 1'b1);
    endtask

    task automatic test_backpressure();
        logic [NN*DW-1:0] v;
        logic [NN*DW-1:0] other;
        bit bad;
        fill(v, 16'h0100);
        v[9*DW +: DW] = 16'h0200;
        run_vec("bp", v, 4'd9, 16'h0200, 1'b0);
        fill(other, 16'h0000);
        other[2*DW +: DW] = 16'h7000;
        node_vec = other;
        in_valid = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (class_idx !== 4'd9 || in_ready !== 1'b0 || out_valid !== 1'b1) bad = 1'b1;
        end
        chk("bp hold stable", {31'd0, bad}, 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp in_ready after release", {31'd0, in_ready}, 32'd1);
        chk("bp out_valid after release", {31'd0, out_valid}, 32'd0);
        chk("bp class_idx held", {28'd0, class_idx}, 32'd9);
    endtask

    task automatic test_reset_mid_scan();
        logic [NN*DW-1:0] v;
        bit seen;
        fill(v, 16'h0005);
        v[4*DW +: DW] = 16'h0444;
        node_vec = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        reset = 1'b1;
        tick();
        chk("mid_scan in_ready in reset", {31'd0, in_ready}, 32'd0);
        reset = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        chk("mid_scan no out_valid", {31'd0, seen}, 32'd0);
        fill(v, 16'h0001);
        v[11*DW +: DW] = 16'h0ABC;
        run_vec("after_reset", v, 4'd11, 16'h0ABC, 1'b1);
    endtask

    // With in_valid and out_ready held high, decisions repeat every 17 cycles.
    task automatic test_back_to_back();
        logic [NN*DW-1:0] v;
        int t = 0;
        int first = -1;
        int second = -1;
        fill(v, 16'h0020);
        v[6*DW +: DW] = 16'h0300;
        node_vec  = v;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        while (second < 0 && t < 80) begin
            tick();
            t++;
            if (out_valid === 1'b1) begin
                if (first < 0) first = t;
                else second = t;
            end
        end
        in_valid  = 1'b0;
        chk("b2b class_idx", {28'd0, class_idx}, 32'd6);
        chk("b2b period", second - first, 32'd17);
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        node_vec  = '0;
        test_reset();
        test_single_max();
        test_tie();
        test_edges();
        test_backpressure();
        test_reset_mid_scan();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
